// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter in front of a single memory port
module mem_bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        we0,
  input  logic        we1,
  input  logic [3:0]  mask0,
  input  logic [3:0]  mask1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic owner, last_served, win, start, finish, timeout, err_q, busy, own;
  logic [CW-1:0] cnt;
  logic [31:0] l_addr, l_wdata;
  logic [3:0] l_mask;
  logic l_we;
  assign win = (req0 && req1) ? ~last_served : req1;
  assign start = (state == IDLE) && (req0 || req1);
  assign timeout = (TIMEOUT != 0) && !mem_ready && (cnt == CW'(TIMEOUT - 1));
  assign finish = (state == BUSY) && (mem_ready || timeout);
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // next state and bus outputs decoded from the current state and owner
  always_comb begin
    state_n = state;
    if (start) state_n = BUSY;
    else if (finish) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
    busy = state == BUSY;
    own = state != IDLE;
    gnt0 = own && !owner;
    gnt1 = own && owner;
    done0 = (state == DONE) && !owner;
    done1 = (state == DONE) && owner;
    err0 = done0 && err_q;
    err1 = done1 && err_q;
    mem_en = busy;
    mem_we = busy && l_we;
    mem_addr = busy ? l_addr : '0;
    mem_wdata = busy ? l_wdata : '0;
    mem_mask = busy ? l_mask : '0;
  end
  // latch the winner and its request fields at the grant edge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner <= 1'b0;
      last_served <= 1'b1;
      l_addr <= '0;
      l_wdata <= '0;
      l_we <= 1'b0;
      l_mask <= '0;
    end else if (start) begin
      owner <= win;
      last_served <= win;
      l_addr <= win ? addr1 : addr0;
      l_wdata <= win ? wdata1 : wdata0;
      l_we <= win ? we1 : we0;
      l_mask <= win ? mask1 : mask0;
    end
  // count BUSY cycles spent waiting for mem_ready
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (start) cnt <= '0;
    else if (busy && !mem_ready) cnt <= cnt + 1'b1;
  // capture completion status and read data for the owner
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_q <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (finish) begin
      err_q <= !mem_ready;
      if (owner) rdata1 <= mem_ready ? mem_rdata : '0;
      else rdata0 <= mem_ready ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: transaction-level randomized check of mem_bus_arbiter
module tb_mem_bus_arbiter;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, mem_ready = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0, mem_rdata = 0;
  logic [3:0] mask0 = 0, mask1 = 0;
  logic gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  logic [3:0] mem_mask;
  int checks = 0, failures = 0;
  logic last;
  logic [31:0] m_rdata [2];
  logic [31:0] fa [2], fwd [2], frd;
  logic fw [2];
  logic [3:0] fm [2];

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1), .mask0(mask0), .mask1(mask1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic rand_fields();
    for (int i = 0; i < 2; i++) begin
      fa[i] = $urandom;
      fwd[i] = $urandom;
      fw[i] = 1'($urandom);
      fm[i] = 4'($urandom);
    end
    frd = $urandom;
  endtask

  // one complete access: rq = requesters asserted, delay = BUSY cycle carrying mem_ready (0 = never)
  task automatic access(input logic [1:0] rq, input int delay, input bit scramble, input bit drop);
    logic win, e;
    int n;
    logic [31:0] exp_rd;
    logic [75:0] act, exp;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_en} !== 7'b0) begin
      failures++;
      $display("FAIL idle outputs=%b required=0000000", {gnt0, gnt1, done0, done1, err0, err1, mem_en});
    end
    req0 = rq[0];
    req1 = rq[1];
    addr0 = fa[0]; addr1 = fa[1];
    wdata0 = fwd[0]; wdata1 = fwd[1];
    we0 = fw[0]; we1 = fw[1];
    mask0 = fm[0]; mask1 = fm[1];
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    win = (rq == 2'b11) ? ~last : rq[1];
    last = win;
    e = !(delay >= 1 && delay <= TO);
    n = e ? TO : delay;
    exp_rd = e ? 32'h0 : frd;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      act = {gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_mask, mem_addr, mem_wdata};
      exp = {!win, win, 4'b0, 1'b1, fw[win], fm[win], fa[win], fwd[win]};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL busy cycle %0d owner %0d: got %h required %h", k, win, act, exp);
      end
      mem_ready = (k == delay);
      mem_rdata = (k == delay) ? frd : $urandom;
      if (scramble) begin
        addr0 = $urandom; addr1 = $urandom;
        wdata0 = $urandom; wdata1 = $urandom;
        we0 = 1'($urandom); we1 = 1'($urandom);
        mask0 = 4'($urandom); mask1 = 4'($urandom);
      end
      if (drop) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we} !== {!win, win, !win, win, !win & e, win & e, 2'b00}) begin
      failures++;
      $display("FAIL done owner %0d: got %b required %b", win, {gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we},
               {!win, win, !win, win, !win & e, win & e, 2'b00});
    end
    m_rdata[win] = exp_rd;
    checks++;
    if ({rdata0, rdata1} !== {m_rdata[0], m_rdata[1]}) begin
      failures++;
      $display("FAIL rdata owner %0d: got %h/%h required %h/%h", win, rdata0, rdata1, m_rdata[0], m_rdata[1]);
    end
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
  endtask

  task automatic test_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_addr, mem_wdata, mem_mask, rdata0, rdata1} !== '0) begin
      failures++;
      $display("FAIL reset outputs: gnt=%b%b done=%b%b err=%b%b en=%b we=%b addr=%h rdata=%h/%h required all zero",
               gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_addr, rdata0, rdata1);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    reset = 1'b0;
    last = 1'b1;
    m_rdata[0] = 0;
    m_rdata[1] = 0;
  endtask

  task automatic test_read();
    rand_fields();
    fa[0] = 32'h100;
    fw[0] = 1'b0;
    frd = 32'hA5A5A5A5;
    access(2'b01, 1, 0, 1);
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      access(2'b11, $urandom_range(1, 4), 1, 0);
    end
  endtask

  task automatic test_write_latch();
    rand_fields();
    fa[1] = 32'h20;
    fwd[1] = 32'h12345678;
    fw[1] = 1'b1;
    fm[1] = 4'b1100;
    access(2'b10, 3, 1, 1);
  endtask

  task automatic test_timeout();
    rand_fields();
    access(2'b01, 0, 0, 0);
    rand_fields();
    access(2'b01, TO, 1, 0);
    rand_fields();
    access(2'b10, TO + 1, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      rand_fields();
      access(2'($urandom_range(1, 3)),
             ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 5),
             1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    rand_fields();
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1;
    addr1 = fa[1];
    we1 = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt1, mem_en} !== 2'b11) begin
      failures++;
      $display("FAIL reset_mid busy: gnt1/mem_en=%b required 11", {gnt1, mem_en});
    end
    #1;
    reset = 1'b1;
    req1 = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, err0, err1, mem_en, mem_we, mem_addr, mem_wdata, mem_mask, rdata0, rdata1} !== '0) begin
      failures++;
      $display("FAIL reset_mid immediate: gnt=%b%b done=%b%b en=%b required all zero", gnt0, gnt1, done0, done1, mem_en);
    end
    @(negedge clk);
    checks++;
    if ({done1, err1, gnt1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_mid held: done1/err1/gnt1=%b required 000", {done1, err1, gnt1});
    end
    mem_ready = 1'b0;
    reset = 1'b0;
    last = 1'b1;
    m_rdata[0] = 0;
    m_rdata[1] = 0;
    rand_fields();
    access(2'b11, 2, 0, 0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_write_latch();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
